// File: rtl/shift_sequencer.sv
// shift_sequencer: command sequencer in front of reg_shifter.
// Accepts one LOAD or SHIFT command at a time. A shift-by-N is issued to
// reg_shifter as N consecutive 1-bit shift cycles.
// Optional build macro SHIFT_AMT_CLAMP_EN: shift amounts above DATA_W are
// clamped to DATA_W on acceptance, because DATA_W shifts already clear the word.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; all outputs 0
// LOAD  | one cycle write of captured word into captured register
// SHIFT | one 1-bit shift per cycle; cnt_q counts down to terminal count 1
// DONE  | one cycle done pulse, still busy
module shift_sequencer #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              op_i,
  input  logic              dir_i,
  input  logic [2:0]        reg_addr_i,
  input  logic [AMT_W-1:0]  amount_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rs_wr_o,
  output logic              rs_shift_o,
  output logic              rs_dir_o,
  output logic [2:0]        rs_rd_a_o,
  output logic [2:0]        rs_wr_addr_o,
  output logic [DATA_W-1:0] rs_d_in_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [2:0]        addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [AMT_W-1:0]  amt_eff;

  // Effective shift count taken at the accepting edge.
`ifdef SHIFT_AMT_CLAMP_EN
  always_comb begin
    amt_eff = amount_i;
    if (32'(amount_i) > 32'(DATA_W)) amt_eff = AMT_W'(DATA_W);
  end
`else
  always_comb begin
    amt_eff = amount_i;
  end
`endif

  // State, counter and captured command fields; synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic; command fields are only captured when accepted in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          dir_d  = dir_i;
          addr_d = reg_addr_i;
          data_d = load_data_i;
          cnt_d  = amt_eff;
          if (!op_i)               state_d = ST_LOAD;
          else if (amt_eff == '0)  state_d = ST_DONE;
          else                     state_d = ST_SHIFT;
        end
      end
      ST_LOAD:  state_d = ST_DONE;
      ST_SHIFT: begin
        // Terminal count at 1 keeps the counter from ever wrapping.
        if (cnt_q == AMT_W'(1)) state_d = ST_DONE;
        else                    cnt_d   = cnt_q - AMT_W'(1);
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore output decode from state and captured fields.
  always_comb begin
    busy_o       = (state_q != ST_IDLE);
    done_o       = 1'b0;
    rs_wr_o      = 1'b0;
    rs_shift_o   = 1'b0;
    rs_dir_o     = 1'b0;
    rs_rd_a_o    = '0;
    rs_wr_addr_o = '0;
    rs_d_in_o    = '0;
    case (state_q)
      ST_LOAD: begin
        rs_wr_o      = 1'b1;
        rs_wr_addr_o = addr_q;
        rs_d_in_o    = data_q;
        rs_rd_a_o    = addr_q;
      end
      ST_SHIFT: begin
        rs_shift_o = 1'b1;
        rs_dir_o   = dir_q;
        rs_rd_a_o  = addr_q;
      end
      ST_DONE: begin
        done_o    = 1'b1;
        rs_rd_a_o = addr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer with a behavioural reg_shifter stand-in.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        start, op, dir;
  logic [2:0]  reg_addr;
  logic [4:0]  amount;
  logic [15:0] load_data;
  logic        busy, done, rs_wr, rs_shift, rs_dir;
  logic [2:0]  rs_rd_a, rs_wr_addr;
  logic [15:0] rs_d_in;

  int tests  = 0;
  int failed = 0;

  logic [15:0] rf [8];

  typedef struct {
    string       tag;
    int          done_c;
    int          shifts;
    int          wrs;
    logic [15:0] regv;
    logic [2:0]  addr;
  } exp_t;
  exp_t exp_q[$];

`ifdef SHIFT_AMT_CLAMP_EN
  localparam int SH20 = 16;
`else
  localparam int SH20 = 20;
`endif

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk_i        (clk),
    .reset_i      (reset_b),
    .start_i      (start),
    .op_i         (op),
    .dir_i        (dir),
    .reg_addr_i   (reg_addr),
    .amount_i     (amount),
    .load_data_i  (load_data),
    .busy_o       (busy),
    .done_o       (done),
    .rs_wr_o      (rs_wr),
    .rs_shift_o   (rs_shift),
    .rs_dir_o     (rs_dir),
    .rs_rd_a_o    (rs_rd_a),
    .rs_wr_addr_o (rs_wr_addr),
    .rs_d_in_o    (rs_d_in)
  );

  // Register file stand-in for reg_shifter.
  always @(posedge clk) begin
    if (rs_wr)         rf[rs_wr_addr] <= rs_d_in;
    else if (rs_shift) rf[rs_rd_a]    <= rs_dir ? (rf[rs_rd_a] >> 1) : (rf[rs_rd_a] << 1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {busy, done, rs_wr, rs_shift, rs_dir, rs_rd_a, rs_wr_addr, rs_d_in}, 32'd0);
  endtask

  // Issue one command from a negedge and score it when done appears.
  task automatic run_cmd(input string tag, input logic op_v, input logic dir_v,
                         input logic [2:0] addr_v, input logic [4:0] amt_v,
                         input logic [15:0] data_v, input int exp_done,
                         input int exp_sh, input int exp_wr,
                         input logic [15:0] exp_reg, input int inject_c);
    exp_t e;
    exp_t got;
    int sh, wr, dc, extra;
    e.tag = tag; e.done_c = exp_done; e.shifts = exp_sh; e.wrs = exp_wr;
    e.regv = exp_reg; e.addr = addr_v;
    exp_q.push_back(e);
    op = op_v; dir = dir_v; reg_addr = addr_v; amount = amt_v; load_data = data_v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = ~op_v; dir = ~dir_v; reg_addr = addr_v ^ 3'd1; amount = 5'd7; load_data = 16'hDEAD;
    sh = 0; wr = 0; dc = -1; extra = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) chk({tag, "_rd_a"}, rs_rd_a, addr_v);
      if (rs_shift) sh++;
      if (rs_wr) wr++;
      if (rs_wr && rs_shift) chk({tag, "_wr_and_shift"}, 1, 0);
      if (done) begin dc = c; break; end
      if (c == inject_c) begin start = 1'b1; op = 1'b0; load_data = 16'hFFFF; end
    end
    got = exp_q.pop_front();
    if (dc < 0) chk({got.tag, "_timeout"}, 0, 1);
    chk({got.tag, "_done_cycle"}, dc, got.done_c);
    chk({got.tag, "_shift_cycles"}, sh, got.shifts);
    chk({got.tag, "_wr_cycles"}, wr, got.wrs);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) chk({got.tag, "_busy_after"}, busy, 0);
      if (done || rs_wr || rs_shift) extra++;
    end
    chk({got.tag, "_no_extra_activity"}, extra, 0);
    chk({got.tag, "_reg"}, rf[got.addr], got.regv);
  endtask

  initial begin
    int seen_done;
    reset_b = 1'b0; start = 1'b0; op = 1'b0; dir = 1'b0;
    reg_addr = '0; amount = '0; load_data = '0;
    repeat (3) @(negedge clk);
    all_zero("reset_outputs");
    reset_b = 1'b1;
    @(negedge clk);
    all_zero("idle_outputs");

    // 1: LOAD r2
    run_cmd("load_r2", 1'b0, 1'b0, 3'd2, 5'd0, 16'h00F3, 2, 0, 1, 16'h00F3, 0);
    // 2: SHIFT r2 left 4
    run_cmd("shl4_r2", 1'b1, 1'b0, 3'd2, 5'd4, 16'h0000, 5, 4, 0, 16'h0F30, 0);
    // 3: SHIFT r2 right 20
    run_cmd("shr20_r2", 1'b1, 1'b1, 3'd2, 5'd20, 16'h0000, SH20 + 1, SH20, 0, 16'h0000, 0);
    // 4: amount 0 leaves register untouched
    run_cmd("load_r3", 1'b0, 1'b0, 3'd3, 5'd0, 16'hA5A5, 2, 0, 1, 16'hA5A5, 0);
    run_cmd("sh0_r3", 1'b1, 1'b0, 3'd3, 5'd0, 16'h1234, 1, 0, 0, 16'hA5A5, 0);
    // 5: start during active shift is ignored
    run_cmd("shl4_busy_start", 1'b1, 1'b0, 3'd3, 5'd4, 16'h0000, 5, 4, 0, 16'h5A50, 2);
    run_cmd("shr1_r3", 1'b1, 1'b1, 3'd3, 5'd1, 16'h0000, 2, 1, 0, 16'h2D28, 0);
    // maximum amount on a cleared register
    run_cmd("load_r5", 1'b0, 1'b0, 3'd5, 5'd0, 16'h8001, 2, 0, 1, 16'h8001, 0);
`ifdef SHIFT_AMT_CLAMP_EN
    run_cmd("shl31_r5", 1'b1, 1'b0, 3'd5, 5'd31, 16'h0000, 17, 16, 0, 16'h0000, 0);
`else
    run_cmd("shl31_r5", 1'b1, 1'b0, 3'd5, 5'd31, 16'h0000, 32, 31, 0, 16'h0000, 0);
`endif

    // 6: reset after 2 of 4 shifts
    run_cmd("load_r2_again", 1'b0, 1'b0, 3'd2, 5'd0, 16'h00F3, 2, 0, 1, 16'h00F3, 0);
    op = 1'b1; dir = 1'b0; reg_addr = 3'd2; amount = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen_done = 0;
    @(negedge clk);
    chk("rst_mid_shift1", rs_shift, 1);
    if (done) seen_done++;
    @(negedge clk);
    chk("rst_mid_shift2", rs_shift, 1);
    if (done) seen_done++;
    reset_b = 1'b0;
    @(negedge clk);
    all_zero("rst_mid_outputs");
    reset_b = 1'b1;
    @(negedge clk);
    if (done) seen_done++;
    all_zero("rst_mid_idle");
    chk("rst_mid_no_done", seen_done, 0);
    chk("rst_mid_reg", rf[2], 16'h03CC);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
